snake_game_core: RTL and testbench

//   Complete snake game engine: movement, growth, food placement, collision detection and pixel colouring.

---
 rtl/snake_game_core.sv | 202 ++++++++++++++++++++
 tb/tb_snake_game_core.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_core.sv
// Snake game engine: steps the snake on a move timer, handles growth, food and
// collisions, and colours the current VGA pixel from the playfield state.
module snake_game_core #(
    parameter int MOVE_TICKS = 6_250_000,
    parameter int MAX_LEN    = 64,
    parameter int INIT_LEN   = 3,
    parameter int CELL_PX    = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [3:0]  direction,
    output logic [11:0] rgb,
    output logic [6:0]  snake_length,
    output logic [5:0]  head_x,
    output logic [5:0]  head_y,
    output logic [4:0]  food_x,
    output logic [4:0]  food_y,
    output logic        game_over
);

    localparam int               CNT_W    = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_TICKS - 1);

    // Heading codes: bit 0 flips between a heading and its reverse.
    localparam logic [1:0] HD_RIGHT = 2'd0;
    localparam logic [1:0] HD_LEFT  = 2'd1;
    localparam logic [1:0] HD_DOWN  = 2'd2;
    localparam logic [1:0] HD_UP    = 2'd3;

    logic [5:0]       seg_x_q [MAX_LEN];
    logic [5:0]       seg_y_q [MAX_LEN];
    logic [6:0]       len_q;
    logic [1:0]       heading_q;
    logic [1:0]       pending_q;
    logic [4:0]       food_x_q;
    logic [4:0]       food_y_q;
    logic             game_over_q;
    logic [11:0]      rgb_q;
    logic [CNT_W-1:0] cnt_q;
    logic [9:0]       lfsr_q;

    logic [1:0]  dir_req_d;
    logic        dir_hit_d;
    logic        dir_ok_d;
    logic [6:0]  next_x_d;
    logic [6:0]  next_y_d;
    logic        step_d;
    logic        wall_d;
    logic        eat_d;
    logic [6:0]  hit_limit_d;
    logic        self_hit_d;
    logic        move_d;
    logic [9:0]  lfsr_d;
    logic [4:0]  lfsr_y_d;
    logic [4:0]  new_food_y_d;
    logic [9:0]  cell_x_d;
    logic [9:0]  cell_y_d;
    logic        head_pix_d;
    logic        body_pix_d;
    logic        food_pix_d;
    logic [11:0] rgb_d;

    // NOTE: every variable assigned in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        dir_hit_d = 1'b1;
        dir_req_d = HD_RIGHT;
        case (direction)
            4'b1000: dir_req_d = HD_UP;
            4'b0100: dir_req_d = HD_DOWN;
            4'b0010: dir_req_d = HD_LEFT;
            4'b0001: dir_req_d = HD_RIGHT;
            default: dir_hit_d = 1'b0;
        endcase
    end

    assign dir_ok_d = dir_hit_d && (dir_req_d != {heading_q[1], ~heading_q[0]});

    // One spare MSB lets a step off the left/top edge wrap to a large value and fail the wall test.
    always_comb begin
        next_x_d = {1'b0, seg_x_q[0]};
        next_y_d = {1'b0, seg_y_q[0]};
        case (pending_q)
            HD_RIGHT: next_x_d = next_x_d + 7'd1;
            HD_LEFT:  next_x_d = next_x_d - 7'd1;
            HD_DOWN:  next_y_d = next_y_d + 7'd1;
            default:  next_y_d = next_y_d - 7'd1;
        endcase
    end

    assign step_d = p_tick && (cnt_q == CNT_LAST) && !game_over_q;
    assign wall_d = (next_x_d > 7'd31) || (next_y_d > 7'd23);
    assign eat_d  = (next_x_d == {2'b00, food_x_q}) && (next_y_d == {2'b00, food_y_q});

    // The tail vacates its cell on a plain move, so it only counts as an obstacle when growing.
    always_comb begin
        hit_limit_d = eat_d ? len_q : len_q - 7'd1;
        self_hit_d  = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((7'(i) < hit_limit_d) && ({1'b0, seg_x_q[i]} == next_x_d) &&
                ({1'b0, seg_y_q[i]} == next_y_d)) begin
                self_hit_d = 1'b1;
            end
        end
    end

    assign move_d       = step_d && !wall_d && !self_hit_d;
    assign lfsr_d       = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    assign lfsr_y_d     = lfsr_q[9:5];
    assign new_food_y_d = (lfsr_y_d >= 5'd24) ? lfsr_y_d - 5'd8 : lfsr_y_d;

    assign cell_x_d   = x / 10'(CELL_PX);
    assign cell_y_d   = y / 10'(CELL_PX);
    assign head_pix_d = (cell_x_d == {4'd0, seg_x_q[0]}) && (cell_y_d == {4'd0, seg_y_q[0]});
    assign food_pix_d = (cell_x_d == {5'd0, food_x_q}) && (cell_y_d == {5'd0, food_y_q});

    always_comb begin
        body_pix_d = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((7'(i) < len_q) && (cell_x_d == {4'd0, seg_x_q[i]}) &&
                (cell_y_d == {4'd0, seg_y_q[i]})) begin
                body_pix_d = 1'b1;
            end
        end
    end

    always_comb begin
        if (!video_on) begin
            rgb_d = 12'h000;
        end else if (game_over_q) begin
            rgb_d = 12'hFFF;
        end else if (head_pix_d) begin
            rgb_d = 12'h0F0;
        end else if (body_pix_d) begin
            rgb_d = 12'h080;
        end else if (food_pix_d) begin
            rgb_d = 12'hF00;
        end else begin
            rgb_d = 12'h000;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the whole segment array is reset so the parallel comparators never see unknowns.
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < INIT_LEN) ? 6'(16 - i) : 6'd0;
                seg_y_q[i] <= (i < INIT_LEN) ? 6'd10 : 6'd0;
            end
            len_q       <= 7'(INIT_LEN);
            heading_q   <= HD_RIGHT;
            pending_q   <= HD_RIGHT;
            food_x_q    <= 5'd8;
            food_y_q    <= 5'd5;
            game_over_q <= 1'b0;
            rgb_q       <= 12'h000;
            cnt_q       <= '0;
            lfsr_q      <= 10'h2A5;
        end else if (p_tick) begin
            lfsr_q <= lfsr_d;
            rgb_q  <= rgb_d;
            cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            if (dir_ok_d) begin
                pending_q <= dir_req_d;
            end
            if (step_d) begin
                heading_q <= pending_q;
                if (wall_d || self_hit_d) begin
                    game_over_q <= 1'b1;
                end
            end
            if (move_d) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg_x_q[i] <= seg_x_q[i-1];
                    seg_y_q[i] <= seg_y_q[i-1];
                end
                seg_x_q[0] <= next_x_d[5:0];
                seg_y_q[0] <= next_y_d[5:0];
                if (eat_d) begin
                    if (len_q < 7'(MAX_LEN)) begin
                        len_q <= len_q + 7'd1;
                    end
                    food_x_q <= lfsr_q[4:0];
                    food_y_q <= new_food_y_d;
                end
            end
        end
    end

    assign rgb          = rgb_q;
    assign snake_length = len_q;
    assign head_x       = seg_x_q[0];
    assign head_y       = seg_y_q[0];
    assign food_x       = food_x_q;
    assign food_y       = food_y_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_snake_game_core.sv
// Bench for snake_game_core: directed scenarios plus randomized play, all checked
// against a queue-based model of the game rules.
module tb_snake_game_core;

    localparam int MT   = 4;
    localparam int MAXL = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_tick;
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  direction;
    logic [11:0] rgb;
    logic [6:0]  snake_length;
    logic [5:0]  head_x;
    logic [5:0]  head_y;
    logic [4:0]  food_x;
    logic [4:0]  food_y;
    logic        game_over;

    snake_game_core #(.MOVE_TICKS(MT), .MAX_LEN(MAXL), .INIT_LEN(3), .CELL_PX(20)) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on), .x(x), .y(y),
        .direction(direction), .rgb(rgb), .snake_length(snake_length), .head_x(head_x),
        .head_y(head_y), .food_x(food_x), .food_y(food_y), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: body as a queue of cells, head at the front; headings as unit vectors.
    int          m_bx[$];
    int          m_by[$];
    int          m_fx, m_fy, m_lfsr, m_cnt;
    int          m_hdx, m_hdy, m_pdx, m_pdy;
    bit          m_go;
    logic [11:0] m_rgb;

    logic [41:0] dut_v;
    assign dut_v = {rgb, snake_length, head_x, head_y, food_x, food_y, game_over};

    function automatic logic [41:0] exp_v();
        return {m_rgb, 7'(m_bx.size()), 6'(m_bx[0]), 6'(m_by[0]), 5'(m_fx), 5'(m_fy), m_go};
    endfunction

    function automatic void model_reset();
        m_bx = '{16, 15, 14};
        m_by = '{10, 10, 10};
        m_fx = 8;  m_fy = 5;
        m_lfsr = 'h2A5;
        m_cnt = 0;
        m_hdx = 1; m_hdy = 0; m_pdx = 1; m_pdy = 0;
        m_go = 1'b0;
        m_rgb = 12'h000;
    endfunction

    function automatic void model_tick(logic [3:0] dir, logic vid, logic [9:0] px, logic [9:0] py);
        int cx = int'(px) / 20;
        int cy = int'(py) / 20;
        int ohx = m_hdx;
        int ohy = m_hdy;
        int nx, ny, lim, rdx, rdy;
        bit eat, hit, rv;
        if (!vid) m_rgb = 12'h000;
        else if (m_go) m_rgb = 12'hFFF;
        else if (cx == m_bx[0] && cy == m_by[0]) m_rgb = 12'h0F0;
        else begin
            m_rgb = (cx == m_fx && cy == m_fy) ? 12'hF00 : 12'h000;
            for (int i = 1; i < m_bx.size(); i++)
                if (cx == m_bx[i] && cy == m_by[i]) m_rgb = 12'h080;
        end
        if (m_cnt == MT - 1) begin
            m_cnt = 0;
            if (!m_go) begin
                nx = m_bx[0] + m_pdx;
                ny = m_by[0] + m_pdy;
                m_hdx = m_pdx; m_hdy = m_pdy;
                if (nx < 0 || nx > 31 || ny < 0 || ny > 23) m_go = 1'b1;
                else begin
                    eat = (nx == m_fx && ny == m_fy);
                    lim = eat ? m_bx.size() : m_bx.size() - 1;
                    hit = 1'b0;
                    for (int i = 0; i < lim; i++)
                        if (m_bx[i] == nx && m_by[i] == ny) hit = 1'b1;
                    if (hit) m_go = 1'b1;
                    else begin
                        m_bx.push_front(nx); m_by.push_front(ny);
                        if (!eat || m_bx.size() > MAXL) begin
                            void'(m_bx.pop_back()); void'(m_by.pop_back());
                        end
                        if (eat) begin
                            m_fx = m_lfsr % 32;
                            m_fy = (m_lfsr / 32) % 32;
                            if (m_fy >= 24) m_fy = m_fy - 8;
                        end
                    end
                end
            end
        end else begin
            m_cnt++;
        end
        rv = 1'b1; rdx = 0; rdy = 0;
        case (dir)
            4'b1000: rdy = -1;
            4'b0100: rdy = 1;
            4'b0010: rdx = -1;
            4'b0001: rdx = 1;
            default: rv = 1'b0;
        endcase
        if (rv && !(rdx == -ohx && rdy == -ohy)) begin
            m_pdx = rdx; m_pdy = rdy;
        end
        m_lfsr = ((m_lfsr * 2) + (((m_lfsr / 512) ^ (m_lfsr / 64)) % 2)) % 1024;
    endfunction

    task automatic drive(input logic rst_v, input logic pt, input logic [3:0] dir,
                         input logic vid, input logic [9:0] px, input logic [9:0] py);
        reset = rst_v; p_tick = pt; direction = dir; video_on = vid; x = px; y = py;
        @(posedge clk);
        if (!rst_v) model_reset();
        else if (pt) model_tick(dir, vid, px, py);
        #1;
    endtask

    function automatic logic [3:0] pick_dir();
        if ($urandom_range(0, 4) == 0) return 4'($urandom_range(0, 15));
        if (m_fx > m_bx[0] && m_hdx != -1) return 4'b0001;
        if (m_fx < m_bx[0] && m_hdx != 1)  return 4'b0010;
        if (m_fy > m_by[0] && m_hdy != -1) return 4'b0100;
        if (m_fy < m_by[0] && m_hdy != 1)  return 4'b1000;
        return (m_hdy == 0) ? 4'b0100 : 4'b0001;
    endfunction

    task automatic test_reset();
        drive(1'b0, 1'b0, 4'b0, 1'b0, 10'd0, 10'd0);
        drive(1'b0, 1'b1, 4'b1000, 1'b1, 10'd330, 10'd210);
        n_vec++;
        if (dut_v !== {12'h000, 7'd3, 6'd16, 6'd10, 5'd8, 5'd5, 1'b0}) begin
            n_miss++;
            $display("FAIL reset_state: got %h required %h", dut_v,
                     {12'h000, 7'd3, 6'd16, 6'd10, 5'd8, 5'd5, 1'b0});
        end
    endtask

    task automatic test_step_timing();
        drive(1'b0, 1'b0, 4'b0, 1'b0, 10'd0, 10'd0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 4'b0, 1'b0, 10'd0, 10'd0);
        n_vec++;
        if ({head_x, head_y, snake_length} !== {6'd17, 6'd10, 7'd3}) begin
            n_miss++;
            $display("FAIL step_4_ticks: got (%0d,%0d) len %0d required (17,10) len 3",
                     head_x, head_y, snake_length);
        end
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 4'b0, 1'b0, 10'd0, 10'd0);
        n_vec++;
        if (dut_v !== exp_v() || head_x !== 6'd17) begin
            n_miss++;
            $display("FAIL ptick_gating: got %h required %h", dut_v, exp_v());
        end
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 4'b0, 1'b0, 10'd0, 10'd0);
        n_vec++;
        if ({head_x, head_y} !== {6'd18, 6'd10}) begin
            n_miss++;
            $display("FAIL step_8_ticks: got (%0d,%0d) required (18,10)", head_x, head_y);
        end
    endtask

    task automatic test_reversal();
        drive(1'b0, 1'b0, 4'b0, 1'b0, 10'd0, 10'd0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 4'b0010, 1'b0, 10'd0, 10'd0);
        n_vec++;
        if ({head_x, head_y} !== {6'd17, 6'd10}) begin
            n_miss++;
            $display("FAIL reversal_ignored: got (%0d,%0d) required (17,10)", head_x, head_y);
        end
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 4'b1001, 1'b0, 10'd0, 10'd0);
        n_vec++;
        if ({head_x, head_y} !== {6'd18, 6'd10}) begin
            n_miss++;
            $display("FAIL multibit_ignored: got (%0d,%0d) required (18,10)", head_x, head_y);
        end
    endtask

    task automatic test_eat();
        drive(1'b0, 1'b0, 4'b0, 1'b0, 10'd0, 10'd0);
        for (int i = 0; i < 52; i++) begin
            drive(1'b1, 1'b1, (i < 20) ? 4'b1000 : 4'b0010, 1'b1,
                  10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)));
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_miss++;
                $display("FAIL eat_path tick %0d: got %h required %h", i, dut_v, exp_v());
            end
        end
        n_vec++;
        if (snake_length !== 7'd4 || {head_x, head_y} !== {6'd8, 6'd5} || food_y >= 5'd24) begin
            n_miss++;
            $display("FAIL eat_growth: got len %0d head (%0d,%0d) food_y %0d required len 4 head (8,5) food_y<24",
                     snake_length, head_x, head_y, food_y);
        end
    endtask

    task automatic test_wall();
        drive(1'b0, 1'b0, 4'b0, 1'b0, 10'd0, 10'd0);
        for (int i = 0; i < 64; i++) drive(1'b1, 1'b1, 4'b0, 1'b0, 10'd0, 10'd0);
        n_vec++;
        if ({game_over, head_x, head_y} !== {1'b1, 6'd31, 6'd10}) begin
            n_miss++;
            $display("FAIL wall_hit: got go %b head (%0d,%0d) required go 1 head (31,10)",
                     game_over, head_x, head_y);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 4'b0001, 1'b1, 10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)));
            n_vec++;
            if (rgb !== 12'hFFF || {head_x, head_y} !== {6'd31, 6'd10} || dut_v !== exp_v()) begin
                n_miss++;
                $display("FAIL wall_frozen: got %h required rgb fff head (31,10), model %h", dut_v, exp_v());
            end
        end
    endtask

    typedef struct {
        logic        pt;
        logic        vid;
        logic [9:0]  px;
        logic [9:0]  py;
        logic [11:0] want;
    } pix_t;

    task automatic test_pixel();
        pix_t tbl [6] = '{
            '{1'b1, 1'b1, 10'd330, 10'd210, 12'h0F0},
            '{1'b1, 1'b1, 10'd290, 10'd210, 12'h080},
            '{1'b1, 1'b0, 10'd330, 10'd210, 12'h000},
            '{1'b1, 1'b1, 10'd170, 10'd110, 12'hF00},
            '{1'b0, 1'b1, 10'd330, 10'd210, 12'hF00},
            '{1'b1, 1'b1, 10'd700, 10'd210, 12'h000}
        };
        drive(1'b0, 1'b0, 4'b0, 1'b0, 10'd0, 10'd0);
        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].pt, 4'b0, tbl[i].vid, tbl[i].px, tbl[i].py);
            n_vec++;
            if (rgb !== tbl[i].want) begin
                n_miss++;
                $display("FAIL pixel_%0d: got rgb %h required %h", i, rgb, tbl[i].want);
            end
        end
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 4'b1000, 1'b1, 10'd330, 10'd190);
        drive(1'b0, 1'b1, 4'b0, 1'b1, 10'd330, 10'd210);
        n_vec++;
        if (dut_v !== {12'h000, 7'd3, 6'd16, 6'd10, 5'd8, 5'd5, 1'b0}) begin
            n_miss++;
            $display("FAIL midgame_reset: got %h required %h", dut_v,
                     {12'h000, 7'd3, 6'd16, 6'd10, 5'd8, 5'd5, 1'b0});
        end
    endtask

    task automatic test_random_play();
        int  post;
        int  reached_full = 0;
        logic [3:0] d;
        for (int g = 0; g < 24; g++) begin
            drive(1'b0, 1'b0, 4'b0, 1'b0, 10'd0, 10'd0);
            post = 0;
            for (int c = 0; c < 1200 && post < 6; c++) begin
                d = pick_dir();
                drive(($urandom_range(0, 599) != 0), ($urandom_range(0, 7) != 0), d,
                      ($urandom_range(0, 5) != 0), 10'($urandom_range(0, 1023)),
                      10'($urandom_range(0, 1023)));
                n_vec++;
                if (dut_v !== exp_v()) begin
                    n_miss++;
                    $display("FAIL random_play game %0d cycle %0d: got %h required %h",
                             g, c, dut_v, exp_v());
                end
                if (m_go) post++;
                if (m_bx.size() == MAXL) reached_full++;
            end
        end
        $display("random play: %0d cycles spent at full length", reached_full);
    endtask

    initial begin
        test_reset();
        test_step_timing();
        test_reversal();
        test_eat();
        test_wall();
        test_pixel();
        test_random_play();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
